// File: rtl/psum_axis_writer_if.sv
// Bundle for psum_axis_writer: the MAC-array capture handshake plus the AXI-Stream master.
// The master modport is the writer's view; the slave modport is the MAC array / DMA side.
interface psum_axis_writer_if #(
    parameter int MAC_NUM = 256,
    parameter int PSUM_W  = 6,
    parameter int AXIS_W  = 32
);
    logic [PSUM_W*MAC_NUM-1:0] psum_in;
    logic                      psum_valid;
    logic                      psum_ready;
    logic [AXIS_W-1:0]         m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic                      m_axis_tlast;

    modport master (
        input  psum_in, psum_valid, m_axis_tready,
        output psum_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output psum_in, psum_valid, m_axis_tready,
        input  psum_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/psum_axis_writer.sv
// Captures one psum vector in a cycle and streams it out byte-packed on AXI-Stream.
// Optional PSUM_RELU_EN: clamp negative psums to zero at packing time.
module psum_lane_pack #(
    parameter int PSUM_W = 6
) (
    input  logic [PSUM_W-1:0] psum_i,
    output logic [7:0]        byte_o
);
`ifdef PSUM_RELU_EN
    assign byte_o = psum_i[PSUM_W-1] ? 8'h00 : 8'(psum_i);
`else
    assign byte_o = 8'($signed(psum_i));
`endif
endmodule

module psum_axis_writer #(
    parameter int MAC_NUM = 256,
    parameter int PSUM_W  = 6,
    parameter int AXIS_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    psum_axis_writer_if.master    bus,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [15:0]           frame_count
);
    localparam int LANES = AXIS_W / 8;
    localparam int BEATS = MAC_NUM / LANES;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [BEATS-1:0][LANES-1:0][PSUM_W-1:0] shadow_t;
    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_q;
    shadow_t                       shadow_q;
    shadow_t                       psum_in_v;
    logic [BCW-1:0]                beat_cnt_q;
    logic [BCW-1:0]                beat_nxt_d;
    logic [LANES-1:0][PSUM_W-1:0]  pack_src_d;
    logic [LANES-1:0][7:0]         pack_byte_d;
    logic [AXIS_W-1:0]             tdata_q;
    logic                          tvalid_q;
    logic                          tlast_q;
    logic [15:0]                   frame_cnt_q;
    logic                          overrun_q;
    logic                          capture_d;
    logic                          last_beat_d;

    assign psum_in_v   = shadow_t'(bus.psum_in);
    assign capture_d   = (state_q == IDLE) && bus.psum_valid;
    assign beat_nxt_d  = beat_cnt_q + BCW'(1);
    assign last_beat_d = (beat_cnt_q == BCW'(BEATS - 1));

    // Beat 0 comes straight from the input so it can be registered on the capture edge.
    assign pack_src_d = (state_q == IDLE) ? psum_in_v[0] : shadow_q[beat_nxt_d];

    psum_lane_pack #(.PSUM_W(PSUM_W)) u_lane [LANES-1:0] (
        .psum_i (pack_src_d),
        .byte_o (pack_byte_d)
    );

    // Data-only storage; no reset needed since it is only read while in SEND.
    always_ff @(posedge clk) begin
        if (capture_d) shadow_q <= psum_in_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (state_q == SEND && bus.psum_valid) overrun_q <= 1'b1;
            else if (overrun_clr)                  overrun_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.psum_valid) begin
                        state_q    <= SEND;
                        beat_cnt_q <= '0;
                        tdata_q    <= AXIS_W'(pack_byte_d);
                        tvalid_q   <= 1'b1;
                        tlast_q    <= (BEATS == 1);
                    end
                end
                SEND: begin
                    if (bus.m_axis_tready) begin
                        if (last_beat_d) begin
                            state_q     <= IDLE;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else begin
                            beat_cnt_q <= beat_nxt_d;
                            tdata_q    <= AXIS_W'(pack_byte_d);
                            tlast_q    <= (beat_nxt_d == BCW'(BEATS - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.psum_ready    = (state_q == IDLE);
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign busy              = (state_q == SEND);
    assign overrun           = overrun_q;
    assign frame_count       = frame_cnt_q;
endmodule

// File: tb/tb_psum_axis_writer.sv
// Directed bench for psum_axis_writer: framing, packing, backpressure, overrun, reset, wrap.
module tb_psum_axis_writer;
    localparam int MAC_NUM = 256;
    localparam int PSUM_W  = 6;
    localparam int AXIS_W  = 32;
    localparam int MW      = MAC_NUM * PSUM_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        overrun_clr;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_count;
    logic [15:0] exp_fc;
    int          vectors = 0;
    int          miscompares = 0;

    psum_axis_writer_if #(.MAC_NUM(MAC_NUM), .PSUM_W(PSUM_W), .AXIS_W(AXIS_W)) bus ();

    psum_axis_writer #(.MAC_NUM(MAC_NUM), .PSUM_W(PSUM_W), .AXIS_W(AXIS_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_beat(input logic [MW-1:0] v, input int b);
        logic [31:0] r;
        logic [5:0]  p;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            p = v[(b*4+k)*6 +: 6];
`ifdef PSUM_RELU_EN
            r[8*k +: 8] = p[5] ? 8'h00 : {2'b00, p};
`else
            r[8*k +: 8] = {{2{p[5]}}, p};
`endif
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] mk_vec(input int mul, input int add, input int modv);
        logic [MW-1:0] v;
        for (int i = 0; i < MAC_NUM; i++) v[i*6 +: 6] = 6'((i*mul + add) % modv);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [MW-1:0] v);
        bus.psum_in    = v;
        bus.psum_valid = 1'b1;
        tick();
        bus.psum_valid = 1'b0;
    endtask

    task automatic drain;
        bus.m_axis_tready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (!bus.m_axis_tvalid) break;
            tick();
        end
        vectors++;
        if (bus.m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_timeout tvalid=%0b want 0", bus.m_axis_tvalid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        overrun_clr = 1'b0;
        bus.psum_valid = 1'b0;
        bus.m_axis_tready = 1'b0;
        bus.psum_in = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_fc = 16'd0;
        vectors += 7;
        if (bus.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %0b want 0", bus.m_axis_tvalid); end
        if (bus.m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got %0b want 0", bus.m_axis_tlast); end
        if (bus.m_axis_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata got %h want 0", bus.m_axis_tdata); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %0b want 0", overrun); end
        if (frame_count !== 16'h0) begin miscompares++; $display("FAIL reset_frame_count got %h want 0", frame_count); end
        if (bus.psum_ready !== 1'b1) begin miscompares++; $display("FAIL reset_psum_ready got %0b want 1", bus.psum_ready); end
    endtask

    task automatic test_single_frame;
        logic [MW-1:0] v;
        v = mk_vec(1, 0, 32);
        bus.m_axis_tready = 1'b1;
        capture(v);
        for (int b = 0; b < 64; b++) begin
            vectors++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== exp_beat(v, b) || bus.m_axis_tlast !== (b == 63)) begin
                miscompares++;
                $display("FAIL single_beat%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         b, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, exp_beat(v, b), (b == 63));
            end
            if (b == 0) begin
                vectors++;
                if (bus.m_axis_tdata !== 32'h03020100) begin miscompares++; $display("FAIL single_beat0_const got %h want 03020100", bus.m_axis_tdata); end
            end
            if (b == 63) begin
                vectors++;
                if (bus.m_axis_tdata !== 32'h1F1E1D1C) begin miscompares++; $display("FAIL single_beat63_const got %h want 1f1e1d1c", bus.m_axis_tdata); end
            end
            tick();
        end
        exp_fc = exp_fc + 16'd1;
        vectors += 4;
        if (frame_count !== exp_fc) begin miscompares++; $display("FAIL single_frame_count got %h want %h", frame_count, exp_fc); end
        if (bus.psum_ready !== 1'b1) begin miscompares++; $display("FAIL single_psum_ready got %0b want 1", bus.psum_ready); end
        if (bus.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL single_tvalid_end got %0b want 0", bus.m_axis_tvalid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_sign;
        logic [MW-1:0] v;
        logic [31:0]   want;
        v = '0;
        v[5:0]   = 6'b111111;
        v[11:6]  = 6'b100000;
        v[17:12] = 6'b011111;
`ifdef PSUM_RELU_EN
        want = 32'h001F0000;
`else
        want = 32'h001FE0FF;
`endif
        bus.m_axis_tready = 1'b0;
        capture(v);
        vectors++;
        if (bus.m_axis_tdata !== want) begin miscompares++; $display("FAIL sign_beat0 got %h want %h", bus.m_axis_tdata, want); end
        drain();
        exp_fc = exp_fc + 16'd1;
    endtask

    task automatic test_backpressure;
        logic [MW-1:0] v;
        logic          will;
        int            hs;
        v = mk_vec(5, 3, 64);
        bus.m_axis_tready = 1'b0;
        capture(v);
        hs = 0;
        for (int cyc = 0; cyc < 400 && hs < 64; cyc++) begin
            bus.m_axis_tready = (cyc % 3 == 0);
            vectors++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== exp_beat(v, hs) || bus.m_axis_tlast !== (hs == 63)) begin
                miscompares++;
                $display("FAIL bp_cyc%0d_beat%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         cyc, hs, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, exp_beat(v, hs), (hs == 63));
            end
            will = bus.m_axis_tready && bus.m_axis_tvalid;
            tick();
            if (will) hs++;
        end
        exp_fc = exp_fc + 16'd1;
        vectors += 3;
        if (hs != 64) begin miscompares++; $display("FAIL bp_handshakes got %0d want 64", hs); end
        if (bus.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL bp_tvalid_end got %0b want 0", bus.m_axis_tvalid); end
        if (frame_count !== exp_fc) begin miscompares++; $display("FAIL bp_frame_count got %h want %h", frame_count, exp_fc); end
    endtask

    task automatic test_overrun;
        logic [MW-1:0] v;
        v = mk_vec(1, 0, 32);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        bus.m_axis_tready = 1'b1;
        capture(v);
        for (int b = 0; b < 64; b++) begin
            bus.psum_valid = (b == 10 || b == 63);
            if (b == 10 || b == 63) bus.psum_in = mk_vec(0, 21, 64);
            vectors++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== exp_beat(v, b) || bus.m_axis_tlast !== (b == 63)) begin
                miscompares++;
                $display("FAIL ovr_beat%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         b, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, exp_beat(v, b), (b == 63));
            end
            tick();
        end
        bus.psum_valid = 1'b0;
        exp_fc = exp_fc + 16'd1;
        vectors += 4;
        if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %0b want 1", overrun); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL ovr_busy got %0b want 0", busy); end
        if (bus.psum_ready !== 1'b1) begin miscompares++; $display("FAIL ovr_psum_ready got %0b want 1", bus.psum_ready); end
        if (frame_count !== exp_fc) begin miscompares++; $display("FAIL ovr_frame_count got %h want %h", frame_count, exp_fc); end

        capture(v);
        tick();
        overrun_clr = 1'b1;
        bus.psum_valid = 1'b1;
        tick();
        bus.psum_valid = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins got %0b want 1", overrun); end
        tick();
        overrun_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %0b want 0", overrun); end
        drain();
        exp_fc = exp_fc + 16'd1;
    endtask

    task automatic test_reset_mid;
        logic [MW-1:0] v;
        v = mk_vec(3, 1, 64);
        bus.m_axis_tready = 1'b1;
        capture(v);
        for (int b = 0; b < 20; b++) begin
            vectors++;
            if (bus.m_axis_tdata !== exp_beat(v, b) || bus.m_axis_tlast !== 1'b0) begin
                miscompares++;
                $display("FAIL rmid_pre_beat%0d got d=%h l=%0b want d=%h l=0", b, bus.m_axis_tdata, bus.m_axis_tlast, exp_beat(v, b));
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_fc = 16'd0;
        vectors += 5;
        if (bus.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rmid_tvalid got %0b want 0", bus.m_axis_tvalid); end
        if (bus.m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL rmid_tlast got %0b want 0", bus.m_axis_tlast); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %0b want 0", busy); end
        if (frame_count !== 16'h0) begin miscompares++; $display("FAIL rmid_frame_count got %h want 0", frame_count); end
        if (bus.psum_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_psum_ready got %0b want 1", bus.psum_ready); end

        v = mk_vec(7, 2, 64);
        capture(v);
        for (int b = 0; b < 64; b++) begin
            vectors++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== exp_beat(v, b) || bus.m_axis_tlast !== (b == 63)) begin
                miscompares++;
                $display("FAIL rmid_post_beat%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         b, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, exp_beat(v, b), (b == 63));
            end
            tick();
        end
        exp_fc = exp_fc + 16'd1;
        vectors++;
        if (frame_count !== exp_fc) begin miscompares++; $display("FAIL rmid_frame_count_post got %h want %h", frame_count, exp_fc); end
    endtask

    task automatic test_wrap;
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        tick();
        vectors++;
        if (frame_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload got %h want ffff", frame_count); end
        capture(mk_vec(1, 0, 32));
        drain();
        vectors++;
        if (frame_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_frame_count got %h want 0000", frame_count); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_sign();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
